// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_TAG    = 4'hA;
    localparam int         HDR_BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational rotating-priority picker: first set request at or after the
// start pointer, wrapping modulo NUM_CH.
module rr_select #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic              found,
    output logic [IDX_W-1:0]  sel
);

    int cand_s;

    // Scan candidates in rotated order; the first hit wins.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        cand_s = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s = (int'(start) + i >= NUM_CH) ? int'(start) + i - NUM_CH
                                                  : int'(start) + i;
            if (!found && req[IDX_W'(cand_s)]) begin
                found = 1'b1;
                sel   = IDX_W'(cand_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_CH byte streams.
// Optional grant header byte enabled with `define UART_ARB_HEADER_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int MAX_BURST = 16,
    localparam int GW        = $clog2(NUM_CH),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*8-1:0]     req_data,
    input  logic [NUM_CH-1:0]       req_last,
    output logic [NUM_CH-1:0]       req_ready,
    output logic                    tx_valid,
    output logic [HDR_BYTE_W-1:0]   tx_data,
    input  logic                    tx_ready,
    output logic                    grant_valid,
    output logic [GW-1:0]           grant_id,
    output logic [BW-1:0]           burst_cnt
);

    arb_state_t          state_r, state_next_s;
    logic [GW-1:0]       rr_ptr_r, rr_ptr_next_s;
    logic [GW-1:0]       grant_id_r, grant_id_next_s;
    logic [BW-1:0]       burst_cnt_r, burst_cnt_next_s;
    logic [NUM_CH-1:0]   eligible_s;
    logic                found_s;
    logic [GW-1:0]       sel_s;
    logic [GW-1:0]       ptr_inc_s;

    assign eligible_s = req_valid & ch_en;
    assign ptr_inc_s  = (grant_id_r == GW'(NUM_CH - 1)) ? '0 : grant_id_r + GW'(1);
    assign grant_id   = grant_id_r;
    assign burst_cnt  = burst_cnt_r;

    rr_select #(
        .NUM_CH (NUM_CH),
        .IDX_W  (GW)
    ) u_rr_select (
        .req   (eligible_s),
        .start (rr_ptr_r),
        .found (found_s),
        .sel   (sel_s)
    );

    // State, pointer, grant and burst counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            grant_id_r  <= '0;
            burst_cnt_r <= '0;
        end else begin
            state_r     <= state_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
            grant_id_r  <= grant_id_next_s;
            burst_cnt_r <= burst_cnt_next_s;
        end
    end

    // Next-state logic and handshake muxing.
    always_comb begin
        state_next_s     = state_r;
        rr_ptr_next_s    = rr_ptr_r;
        grant_id_next_s  = grant_id_r;
        burst_cnt_next_s = burst_cnt_r;
        tx_valid         = 1'b0;
        tx_data          = 8'h00;
        req_ready        = '0;
        grant_valid      = 1'b0;

        case (state_r)
            IDLE: begin
                // The final count of the previous grant stays visible for the gap cycle.
                burst_cnt_next_s = '0;
                if (found_s) begin
                    grant_id_next_s = sel_s;
`ifdef UART_ARB_HEADER_EN
                    state_next_s    = HDR;
`else
                    state_next_s    = SEND;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef UART_ARB_HEADER_EN
            HDR: begin
                grant_valid = 1'b1;
                tx_valid    = 1'b1;
                tx_data     = {HDR_TAG, 4'(grant_id_r)};
                if (tx_ready) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = HDR;
                end
            end
`endif
            SEND: begin
                grant_valid = 1'b1;
                tx_valid    = req_valid[grant_id_r];
                tx_data     = req_data[{grant_id_r, 3'b000} +: 8];
                if (!req_valid[grant_id_r]) begin
                    state_next_s  = IDLE;
                    rr_ptr_next_s = ptr_inc_s;
                end else if (tx_ready) begin
                    req_ready[grant_id_r] = 1'b1;
                    burst_cnt_next_s      = burst_cnt_r + BW'(1);
                    if (req_last[grant_id_r] || (burst_cnt_r == BW'(MAX_BURST - 1))) begin
                        state_next_s  = IDLE;
                        rr_ptr_next_s = ptr_inc_s;
                    end else begin
                        state_next_s = SEND;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_CH=4, MAX_BURST=16).
module tb_uart_tx_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  ch_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [4:0]  burst_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_tx_arbiter #(.NUM_CH(4), .MAX_BURST(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ch_en       (ch_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_cnt   (burst_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        rdy;
        logic        e_tv;
        logic [7:0]  e_td;
        logic [3:0]  e_rr;
        logic        e_gv;
        logic [1:0]  e_gid;
        logic [4:0]  e_bc;
        logic        ck_ptr;
        logic [1:0]  e_ptr;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic tv, input logic [7:0] td,
                            input logic [3:0] rr, input logic gv, input logic [1:0] gid,
                            input logic [4:0] bc);
        chk({tag, ".tx_valid"},    32'(tx_valid),    32'(tv));
        chk({tag, ".tx_data"},     32'(tx_data),     32'(td));
        chk({tag, ".req_ready"},   32'(req_ready),   32'(rr));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, ".grant_id"},    32'(grant_id),    32'(gid));
        chk({tag, ".burst_cnt"},   32'(burst_cnt),   32'(bc));
    endtask

    initial begin
        RST       = 1'b1;
        ch_en     = 4'h0;
        req_valid = 4'h0;
        req_data  = 32'h0;
        req_last  = 4'h0;
        tx_ready  = 1'b0;
        #1;
        chk_outs("reset", 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd0);
        step();
        step();
        RST = 1'b0;

`ifdef UART_ARB_HEADER_EN
        // Header build: ch3 sends one byte 0x7E preceded by header 0xA3.
        ch_en = 4'hF; req_valid = 4'h8; req_last = 4'h8; req_data = 32'h7E00_0000; tx_ready = 1'b1;
        #1;
        chk("hdr_idle_gv", 32'(grant_valid), 32'd0);
        step();
        chk_outs("hdr_byte", 1'b1, 8'hA3, 4'h0, 1'b1, 2'd3, 5'd0);
        step();
        chk_outs("hdr_data", 1'b1, 8'h7E, 4'h8, 1'b1, 2'd3, 5'd0);
        step();
        req_valid = 4'h0;
        #1;
        chk("hdr_rel_gv", 32'(grant_valid), 32'd0);
        chk("hdr_rel_bc", 32'(burst_cnt), 32'd1);
`else
        //              en    vld   lst   dat            rdy   tv    td     rr    gv    gid   bc    ckp   ptr
        tbl[0]  = '{4'hF, 4'h4, 4'h0, 32'h0011_0000, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0};
        tbl[1]  = '{4'hF, 4'h4, 4'h0, 32'h0011_0000, 1'b1, 1'b1, 8'h11, 4'h4, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0};
        tbl[2]  = '{4'hF, 4'h4, 4'h4, 32'h0022_0000, 1'b1, 1'b1, 8'h22, 4'h4, 1'b1, 2'd2, 5'd1, 1'b0, 2'd0};
        tbl[3]  = '{4'hF, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd2, 5'd2, 1'b1, 2'd3};
        tbl[4]  = '{4'hF, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd2, 5'd0, 1'b0, 2'd0};
        tbl[5]  = '{4'hF, 4'h1, 4'h0, 32'h0000_00A5, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd2, 5'd0, 1'b0, 2'd0};
        tbl[6]  = '{4'hF, 4'h1, 4'h0, 32'h0000_00A5, 1'b0, 1'b1, 8'hA5, 4'h0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0};
        tbl[7]  = '{4'hF, 4'h1, 4'h0, 32'h0000_00A5, 1'b0, 1'b1, 8'hA5, 4'h0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0};
        tbl[8]  = '{4'hF, 4'h1, 4'h0, 32'h0000_00A5, 1'b1, 1'b1, 8'hA5, 4'h1, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0};
        tbl[9]  = '{4'hF, 4'h1, 4'h1, 32'h0000_005A, 1'b0, 1'b1, 8'h5A, 4'h0, 1'b1, 2'd0, 5'd1, 1'b0, 2'd0};
        tbl[10] = '{4'hF, 4'h1, 4'h1, 32'h0000_005A, 1'b1, 1'b1, 8'h5A, 4'h1, 1'b1, 2'd0, 5'd1, 1'b0, 2'd0};
        tbl[11] = '{4'hF, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd2, 1'b1, 2'd1};
        tbl[12] = '{4'hD, 4'h2, 4'h0, 32'h0000_3300, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0};
        tbl[13] = '{4'hD, 4'h2, 4'h0, 32'h0000_3300, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0};
        tbl[14] = '{4'hD, 4'h2, 4'h0, 32'h0000_3300, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0};

        for (int i = 0; i < 15; i++) begin
            ch_en = tbl[i].en; req_valid = tbl[i].vld; req_last = tbl[i].lst;
            req_data = tbl[i].dat; tx_ready = tbl[i].rdy;
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_tv, tbl[i].e_td, tbl[i].e_rr,
                     tbl[i].e_gv, tbl[i].e_gid, tbl[i].e_bc);
            if (tbl[i].ck_ptr) begin
                chk($sformatf("vec%0d.rr_ptr", i), 32'(dut.rr_ptr_r), 32'(tbl[i].e_ptr));
            end else begin
                total_cnt = total_cnt;
            end
            step();
        end

        // Burst limit: ch1 offers 20 bytes with no last marker.
        begin
            int idx = 0;
            int grants = 0;
            int g1 = 0;
            int g2 = 0;
            int maxb = 0;
            logic prev_gv = 1'b0;
            ch_en = 4'hF; req_last = 4'h0; tx_ready = 1'b1;
            for (int cyc = 0; cyc < 30; cyc++) begin
                req_valid = (idx < 20) ? 4'h2 : 4'h0;
                req_data  = {16'h0, 8'(idx + 1), 8'h00};
                #1;
                if (grant_valid && !prev_gv) grants++;
                if (req_ready[1]) begin
                    chk("burst.data", 32'(tx_data), 32'(idx + 1));
                    if (grants == 1) g1++; else g2++;
                    idx++;
                end
                if (int'(burst_cnt) > maxb) maxb = int'(burst_cnt);
                prev_gv = grant_valid;
                step();
            end
            chk("burst.first_grant_bytes", 32'(g1), 32'd16);
            chk("burst.second_grant_bytes", 32'(g2), 32'd4);
            chk("burst.max_cnt", 32'(maxb), 32'd16);
            chk("burst.grants", 32'(grants), 32'd2);
        end

        // Reset mid-burst on ch3 after two accepted bytes.
        ch_en = 4'hF; req_valid = 4'h8; req_last = 4'h0; req_data = 32'hC300_0000; tx_ready = 1'b1;
        #1;
        chk("rst3.idle_gv", 32'(grant_valid), 32'd0);
        step();
        chk_outs("rst3.b0", 1'b1, 8'hC3, 4'h8, 1'b1, 2'd3, 5'd0);
        step();
        chk("rst3.b1_cnt", 32'(burst_cnt), 32'd1);
        step();
        chk("rst3.b2_cnt", 32'(burst_cnt), 32'd2);
        RST = 1'b1;
        #1;
        chk_outs("rst3.abort", 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 5'd0);
        chk("rst3.rr_ptr", 32'(dut.rr_ptr_r), 32'd0);
        step();
        RST = 1'b0;

        // Round-robin: every channel always ready with single-byte packets.
        ch_en = 4'hF; req_valid = 4'hF; req_last = 4'hF; req_data = 32'h4030_2010; tx_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d.gap_gv", k), 32'(grant_valid), 32'd0);
            step();
            chk($sformatf("rr%0d.gv", k), 32'(grant_valid), 32'd1);
            chk($sformatf("rr%0d.gid", k), 32'(grant_id), 32'(k % 4));
            chk($sformatf("rr%0d.data", k), 32'(tx_data), 32'((k % 4 + 1) * 16));
            chk($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(1 << (k % 4)));
            step();
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
